alu_driver: RTL and testbench
=============================

ALU_DRIVER -- requirements
Module: alu_driver

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 req_valid  input  1  request present; req_ready  output  1  driver can accept (high only in IDLE).
REQ-004 req_aluop  input  2  00=add, 01=sub, 10=decode req_funct, 11=unsupported.
REQ-005 req_funct  input  6  MIPS funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 011001 MULTU.
REQ-006 req_a, req_b  input  32 each  operands.
REQ-007 alu_a, alu_b  output  32 each; alu_f  output  3; ALU operand/control drive (f: 010 add, 110 sub, 000 and, 001 or, 111 slt).
REQ-008 alu_y  input  32; alu_cout  input  1; combinational ALU result returned in the same cycle.
REQ-009 rsp_valid  output  1; rsp_ready  input  1; response handshake.
REQ-010 rsp_y  output  32  result (LO word for MULTU); rsp_hi  output  32  HI word (0 for non-MULTU); rsp_cout  output  1; rsp_err  output  1  unsupported op.

Function
REQ-011 Request accepted at edge N when req_valid && req_ready; operands, f code and op class registered at that edge.
REQ-012 FSM states IDLE, EXEC, MUL, DONE; IDLE->EXEC (single-cycle op), IDLE->MUL (MULTU), IDLE->DONE (unsupported), EXEC->DONE, MUL->DONE after 32 iterations, DONE->IDLE on rsp_valid && rsp_ready.
REQ-013 EXEC (cycle N+1): alu_a/alu_b = registered operands, alu_f = decoded code; edge N+2 captures rsp_y=alu_y, rsp_cout=alu_cout, rsp_hi=0; rsp_valid high from cycle N+2.
REQ-014 MULTU: unsigned shift-add; registers hi (33 bits incl. carry), lo=multiplier, mcand=multiplicand; hi and carry cleared at accept.
REQ-015 Each MUL cycle: alu_a=hi[31:0], alu_b = lo[0] ? mcand : 0, alu_f=010; next {carry,hi,lo} = {0, alu_cout, alu_y, lo} >> 1.
REQ-016 Exactly 32 MUL cycles (N+1..N+32), 5-bit iteration counter; rsp_valid from cycle N+33 with rsp_hi=hi, rsp_y=lo, rsp_cout=0.
REQ-017 Unsupported op (aluop 11 or unknown funct): no ALU cycle; rsp_valid from cycle N+1, rsp_err=1, rsp_y=0, rsp_hi=0, rsp_cout=0.
REQ-018 Outside EXEC/MUL: alu_a=0, alu_b=0, alu_f=010.
REQ-019 rsp_* held stable while rsp_valid && !rsp_ready; no new request accepted until DONE->IDLE (req_ready low in EXEC/MUL/DONE, no same-cycle accept on handshake edge).
REQ-020 rsp_err cleared on every accepted supported request.

Reset
REQ-021 Reset at any edge, including mid-MUL or in DONE, forces IDLE, aborts operation, no response issued.
REQ-022 Reset values: req_ready=1 (after reset deasserts), rsp_valid=0, rsp_y=0, rsp_hi=0, rsp_cout=0, rsp_err=0, counter=0, alu_a=0, alu_b=0, alu_f=010.

Structure
REQ-023 Shared package alu_pkg SHALL hold ALU f-code constants, funct constants, aluop constants and the state enum typedef.
REQ-024 One combinational sub-module alu_dec SHALL map (aluop, funct) to f code, is_mul and err; FSM and datapath stay in alu_driver.
REQ-025 Bench SHALL connect alu_driver to the team's existing 32-bit alu (a, b, f, cout, y).

Verification
REQ-026 ADD funct, a=3, b=5 -> rsp_valid at N+2, rsp_y=8, rsp_cout=0, rsp_hi=0.
REQ-027 aluop 01, a=12, b=24 -> rsp_y=FFFFFFF4, rsp_cout=0; SLT a=31, b=40 -> rsp_y=1; SLT a=32, b=31 -> rsp_y=0.
REQ-028 MULTU a=FFFFFFFF, b=FFFFFFFF -> rsp_valid at N+33, rsp_hi=FFFFFFFE, rsp_y=00000001; a=7, b=6 -> hi=0, y=2A.
REQ-029 rsp_ready low 5 cycles after rsp_valid -> outputs stable, req_ready low; req_valid held high -> next request accepted only after handshake edge.
REQ-030 funct 000000 -> rsp_valid at N+1, rsp_err=1, rsp_y=0; following ADD clears rsp_err.
REQ-031 reset asserted at MUL iteration 10 -> next cycle IDLE, rsp_valid=0, alu_f=010; fresh ADD 3+5 then returns 8 at N+2.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU driver: ALU f codes, MIPS funct
// codes, aluop classes, datapath widths and the driver state enum.
package alu_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned CNT_W   = 5;
   localparam int unsigned F_W     = 3;
   localparam int unsigned FUNCT_W = 6;
   localparam int unsigned AOP_W   = 2;

   // ALU control codes
   localparam logic [F_W-1:0] F_AND = 3'b000;
   localparam logic [F_W-1:0] F_OR  = 3'b001;
   localparam logic [F_W-1:0] F_ADD = 3'b010;
   localparam logic [F_W-1:0] F_SUB = 3'b110;
   localparam logic [F_W-1:0] F_SLT = 3'b111;

   // MIPS R-type funct codes
   localparam logic [FUNCT_W-1:0] FN_ADD   = 6'b100000;
   localparam logic [FUNCT_W-1:0] FN_SUB   = 6'b100010;
   localparam logic [FUNCT_W-1:0] FN_AND   = 6'b100100;
   localparam logic [FUNCT_W-1:0] FN_OR    = 6'b100101;
   localparam logic [FUNCT_W-1:0] FN_SLT   = 6'b101010;
   localparam logic [FUNCT_W-1:0] FN_MULTU = 6'b011001;

   // aluop classes
   localparam logic [AOP_W-1:0] AOP_ADD   = 2'b00;
   localparam logic [AOP_W-1:0] AOP_SUB   = 2'b01;
   localparam logic [AOP_W-1:0] AOP_FUNCT = 2'b10;
   localparam logic [AOP_W-1:0] AOP_NONE  = 2'b11;

   // Last iteration index of the 32-step shift-add multiply
   localparam logic [CNT_W-1:0] MUL_LAST = 5'd31;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_MUL  = 2'b10,
      ST_DONE = 2'b11
   } state_t;

endpackage

// File: rtl/alu_dec.sv
// Combinational operation decoder.
// Ports:
//   aluop    in   2  operation class
//   funct    in   6  MIPS funct (used only for aluop 10)
//   f_c      out  3  ALU control code
//   is_mul_c out  1  request is MULTU
//   err_c    out  1  request is unsupported
module alu_dec
   import alu_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [5:0] funct,
   output logic [2:0] f_c,
   output logic       is_mul_c,
   output logic       err_c
);

   // aluop/funct -> f code; MULTU drives the adder, anything unknown flags err
   always_comb begin
      f_c      = F_ADD;
      is_mul_c = 1'b0;
      err_c    = 1'b0;
      case (aluop)
         AOP_ADD: f_c = F_ADD;
         AOP_SUB: f_c = F_SUB;
         AOP_FUNCT: begin
            case (funct)
               FN_ADD:   f_c = F_ADD;
               FN_SUB:   f_c = F_SUB;
               FN_AND:   f_c = F_AND;
               FN_OR:    f_c = F_OR;
               FN_SLT:   f_c = F_SLT;
               FN_MULTU: is_mul_c = 1'b1;
               default:  err_c = 1'b1;
            endcase
         end
         default: err_c = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_driver.sv
// Request/response driver for an external combinational 32-bit ALU.
// Single-cycle ops take one ALU cycle; MULTU runs a 32-step unsigned
// shift-add multiply through the ALU adder; unsupported ops answer at once.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   req_valid/req_ready          request handshake (ready only in IDLE)
//   req_aluop, req_funct         operation select
//   req_a, req_b                 operands
//   alu_a, alu_b, alu_f          ALU operand/control drive
//   alu_y, alu_cout              ALU result, same cycle
//   rsp_valid/rsp_ready          response handshake
//   rsp_y, rsp_hi, rsp_cout      result (LO / HI word for MULTU), carry
//   rsp_err                      unsupported operation
module alu_driver
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_aluop,
   input  logic [5:0]  req_funct,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [2:0]  alu_f,
   input  logic [31:0] alu_y,
   input  logic        alu_cout,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_y,
   output logic [31:0] rsp_hi,
   output logic        rsp_cout,
   output logic        rsp_err
);

   state_t              r_state;
   state_t              w_next;
   logic [DATA_W-1:0]   r_opa;     // operand a / multiplicand
   logic [DATA_W-1:0]   r_opb;     // operand b / multiplier shifting into LO
   logic [DATA_W-1:0]   r_hi;
   logic [F_W-1:0]      r_f;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_rsp_valid;
   logic [DATA_W-1:0]   r_rsp_y;
   logic [DATA_W-1:0]   r_rsp_hi;
   logic                r_rsp_cout;
   logic                r_rsp_err;

   logic [F_W-1:0]      w_dec_f;
   logic                w_dec_mul;
   logic                w_dec_err;
   logic                w_accept;
   logic [DATA_W-1:0]   w_mul_hi;
   logic [DATA_W-1:0]   w_mul_lo;

   alu_dec u_dec (
      .aluop    (req_aluop),
      .funct    (req_funct),
      .f_c      (w_dec_f),
      .is_mul_c (w_dec_mul),
      .err_c    (w_dec_err)
   );

   assign req_ready = (r_state == ST_IDLE);
   assign w_accept  = req_valid && req_ready;

   // One shift-add step: {cout, y, lo} >> 1. The 33rd hi bit (carry) is the
   // ALU carry-out consumed on the same edge, so it never needs its own flop.
   assign w_mul_hi = {alu_cout, alu_y[DATA_W-1:1]};
   assign w_mul_lo = {alu_y[0], r_opb[DATA_W-1:1]};

   assign rsp_valid = r_rsp_valid;
   assign rsp_y     = r_rsp_y;
   assign rsp_hi    = r_rsp_hi;
   assign rsp_cout  = r_rsp_cout;
   assign rsp_err   = r_rsp_err;

   // Next state and ALU drive
   always_comb begin
      w_next = r_state;
      alu_a  = '0;
      alu_b  = '0;
      alu_f  = F_ADD;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_dec_err)      w_next = ST_DONE;
               else if (w_dec_mul) w_next = ST_MUL;
               else                w_next = ST_EXEC;
            end
         end
         ST_EXEC: begin
            alu_a  = r_opa;
            alu_b  = r_opb;
            alu_f  = r_f;
            w_next = ST_DONE;
         end
         ST_MUL: begin
            alu_a = r_hi;
            alu_b = r_opb[0] ? r_opa : '0;
            alu_f = F_ADD;
            if (r_cnt == MUL_LAST) w_next = ST_DONE;
         end
         ST_DONE: begin
            if (r_rsp_valid && rsp_ready) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // State register and datapath
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_opa       <= '0;
         r_opb       <= '0;
         r_hi        <= '0;
         r_f         <= F_ADD;
         r_cnt       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_y     <= '0;
         r_rsp_hi    <= '0;
         r_rsp_cout  <= 1'b0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_opa     <= req_a;
                  r_opb     <= req_b;
                  r_f       <= w_dec_f;
                  r_hi      <= '0;
                  r_cnt     <= '0;
                  r_rsp_err <= w_dec_err;
                  if (w_dec_err) begin
                     r_rsp_valid <= 1'b1;
                     r_rsp_y     <= '0;
                     r_rsp_hi    <= '0;
                     r_rsp_cout  <= 1'b0;
                  end
               end
            end
            ST_EXEC: begin
               r_rsp_valid <= 1'b1;
               r_rsp_y     <= alu_y;
               r_rsp_hi    <= '0;
               r_rsp_cout  <= alu_cout;
            end
            ST_MUL: begin
               r_hi  <= w_mul_hi;
               r_opb <= w_mul_lo;
               r_cnt <= CNT_W'(r_cnt + 1'b1);
               if (r_cnt == MUL_LAST) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_y     <= w_mul_lo;
                  r_rsp_hi    <= w_mul_hi;
                  r_rsp_cout  <= 1'b0;
               end
            end
            ST_DONE: begin
               if (rsp_ready) r_rsp_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_driver.sv
// Self-checking bench for alu_driver with a behavioural 32-bit ALU model.
module tb_alu_driver;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_aluop;
   logic [5:0]  req_funct;
   logic [31:0] req_a, req_b;
   logic [31:0] alu_a, alu_b, alu_y;
   logic [2:0]  alu_f;
   logic        alu_cout;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_y, rsp_hi;
   logic        rsp_cout, rsp_err;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [31:0] y;
      logic [31:0] hi;
      logic        cout;
      logic        err;
      int          lat;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   alu_driver dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_aluop (req_aluop),
      .req_funct (req_funct),
      .req_a     (req_a),
      .req_b     (req_b),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_f     (alu_f),
      .alu_y     (alu_y),
      .alu_cout  (alu_cout),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_y     (rsp_y),
      .rsp_hi    (rsp_hi),
      .rsp_cout  (rsp_cout),
      .rsp_err   (rsp_err)
   );

   // 32-bit ALU: f[2] inverts b and injects carry-in, f[1:0] selects result
   logic [31:0] w_bb;
   logic [32:0] w_sum;
   always_comb begin
      w_bb     = alu_f[2] ? ~alu_b : alu_b;
      w_sum    = {1'b0, alu_a} + {1'b0, w_bb} + 33'(alu_f[2]);
      alu_cout = w_sum[32];
      case (alu_f[1:0])
         2'b00:   alu_y = alu_a & w_bb;
         2'b01:   alu_y = alu_a | w_bb;
         2'b10:   alu_y = w_sum[31:0];
         default: alu_y = {31'd0, w_sum[31]};
      endcase
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] y, input logic [31:0] hi,
                               input logic cout, input logic err, input int lat);
      exp_t e;
      e.y = y; e.hi = hi; e.cout = cout; e.err = err; e.lat = lat;
      return e;
   endfunction

   // Issue one request (called at a negedge, returns at a negedge).
   task automatic run(input logic [1:0] op, input logic [5:0] fn,
                      input logic [31:0] a, input logic [31:0] b,
                      input int stall, input bit hold, input exp_t e);
      int lat;
      bit seen;
      int g;
      exp_t x;
      logic [31:0] y0, hi0;
      logic        c0, e0;
      sb.push_back(e);
      req_valid = 1'b1; req_aluop = op; req_funct = fn; req_a = a; req_b = b;
      g = 0;
      while (!req_ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      if (!req_ready) check("accept_timeout", 64'(req_ready), 64'd1);
      @(posedge clk);
      lat  = 0;
      seen = 1'b0;
      for (int i = 0; i < 64 && !seen; i++) begin
         @(negedge clk);
         lat++;
         if (!hold) req_valid = 1'b0;
         if (rsp_valid) seen = 1'b1;
      end
      if (!seen) check("rsp_timeout", 64'(rsp_valid), 64'd1);
      y0 = rsp_y; hi0 = rsp_hi; c0 = rsp_cout; e0 = rsp_err;
      check("done_alu_f", 64'(alu_f), 64'(F_ADD));
      for (int s = 0; s < stall; s++) begin
         check("stall_req_ready", 64'(req_ready), 64'd0);
         @(negedge clk);
         check("stall_valid", 64'(rsp_valid), 64'd1);
         check("stall_hold", {rsp_y, rsp_hi}, {y0, hi0});
         check("stall_flags", {62'd0, rsp_cout, rsp_err}, {62'd0, c0, e0});
      end
      x = sb.pop_front();
      check("latency", 64'(lat), 64'(x.lat));
      check("rsp_y", 64'(rsp_y), 64'(x.y));
      check("rsp_hi", 64'(rsp_hi), 64'(x.hi));
      check("rsp_cout", 64'(rsp_cout), 64'(x.cout));
      check("rsp_err", 64'(rsp_err), 64'(x.err));
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      check("post_hs_valid", 64'(rsp_valid), 64'd0);
      check("post_hs_ready", 64'(req_ready), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_aluop = '0; req_funct = '0;
      req_a = '0; req_b = '0; rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("rst_req_ready", 64'(req_ready), 64'd1);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp", {rsp_y, rsp_hi}, 64'd0);
      check("rst_flags", {62'd0, rsp_cout, rsp_err}, 64'd0);
      check("rst_alu_ab", {alu_a, alu_b}, 64'd0);
      check("rst_alu_f", 64'(alu_f), 64'(F_ADD));

      run(AOP_FUNCT, FN_ADD, 32'd3, 32'd5, 0, 1'b0, mk(32'd8, 32'd0, 1'b0, 1'b0, 2));
      run(AOP_SUB, 6'd0, 32'd12, 32'd24, 0, 1'b0, mk(32'hFFFF_FFF4, 32'd0, 1'b0, 1'b0, 2));
      run(AOP_FUNCT, FN_SLT, 32'd31, 32'd40, 0, 1'b0, mk(32'd1, 32'd0, 1'b0, 1'b0, 2));
      run(AOP_FUNCT, FN_SLT, 32'd32, 32'd31, 0, 1'b0, mk(32'd0, 32'd0, 1'b1, 1'b0, 2));
      run(AOP_FUNCT, FN_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 0, 1'b0,
          mk(32'h0F00_0F00, 32'd0, 1'b1, 1'b0, 2));
      run(AOP_FUNCT, FN_OR, 32'hFF00_FF00, 32'h0F0F_0F0F, 0, 1'b0,
          mk(32'hFF0F_FF0F, 32'd0, 1'b1, 1'b0, 2));
      run(AOP_FUNCT, FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0,
          mk(32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 33));
      run(AOP_FUNCT, FN_MULTU, 32'd7, 32'd6, 0, 1'b0, mk(32'h2A, 32'd0, 1'b0, 1'b0, 33));

      // back-pressure with request held high across the response
      run(AOP_ADD, 6'd0, 32'h8000_0000, 32'h8000_0001, 5, 1'b1,
          mk(32'd1, 32'd0, 1'b1, 1'b0, 2));
      run(AOP_FUNCT, FN_SUB, 32'd100, 32'd1, 0, 1'b0, mk(32'd99, 32'd0, 1'b1, 1'b0, 2));

      // unsupported ops, then a supported op clears err
      run(AOP_FUNCT, 6'b000000, 32'd9, 32'd9, 0, 1'b0, mk(32'd0, 32'd0, 1'b0, 1'b1, 1));
      run(AOP_FUNCT, FN_ADD, 32'd3, 32'd5, 0, 1'b0, mk(32'd8, 32'd0, 1'b0, 1'b0, 2));
      run(AOP_NONE, FN_ADD, 32'd1, 32'd1, 2, 1'b0, mk(32'd0, 32'd0, 1'b0, 1'b1, 1));

      // reset in the middle of a multiply
      req_valid = 1'b1; req_aluop = AOP_FUNCT; req_funct = FN_MULTU;
      req_a = 32'd1234; req_b = 32'd5678;
      check("mul_start_ready", 64'(req_ready), 64'd1);
      @(posedge clk);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         req_valid = 1'b0;
      end
      check("mul_busy_ready", 64'(req_ready), 64'd0);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("abort_valid", 64'(rsp_valid), 64'd0);
      check("abort_alu_f", 64'(alu_f), 64'(F_ADD));
      check("abort_alu_ab", {alu_a, alu_b}, 64'd0);
      check("abort_ready", 64'(req_ready), 64'd1);
      check("abort_rsp_y", 64'(rsp_y), 64'd0);
      run(AOP_FUNCT, FN_ADD, 32'd3, 32'd5, 0, 1'b0, mk(32'd8, 32'd0, 1'b0, 1'b0, 2));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
